// File: rtl/lsu_pkg.sv
//==============================================================================
// Module  : lsu_pkg
// Brief   : Shared constants, FSM state encoding and size decode for the LSU.
// Revision: 1.0
//==============================================================================
`default_nettype none

package lsu_pkg;

    localparam int c_XLEN   = 32;
    localparam int c_ADDR_W = 32;
    localparam int c_STRB_W = c_XLEN / 8;
    localparam int c_OFF_W  = $clog2(c_STRB_W);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Any encoding that is not a byte or half access behaves as a word.
    function automatic lsu_size_t lsu_size(input logic [2:0] funct3);
        case (funct3)
            c_F3_B, c_F3_BU: return SZ_B;
            c_F3_H, c_F3_HU: return SZ_H;
            c_F3_W:          return SZ_W;
            default:         return SZ_W;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
//==============================================================================
// Module  : lsu_align
// Brief   : Store lane steering, load extraction/extension and misalign flag.
//           Misalign detection only with YSYX_23060251_LSU_MISALIGN_CHK_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN   = c_XLEN,
    parameter int STRB_W = c_STRB_W,
    parameter int OFF_W  = c_OFF_W
) (
    input  logic [2:0]        i_funct3,
    input  logic [OFF_W-1:0]  i_off,
    input  logic [XLEN-1:0]   i_src2,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic [XLEN-1:0]   o_wdata,
    output logic [XLEN-1:0]   o_load_data,
    output logic              o_misaligned
);

    lsu_size_t   w_size;
    logic        w_signed;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_size   = lsu_size(i_funct3);
    assign w_signed = ~i_funct3[2];
    assign w_half   = 16'(i_rdata >> {i_off, 3'b000});
    assign w_byte   = w_half[7:0];

    // Shifted strobes simply drop lanes that would cross the word boundary.
    always_comb begin
        o_wstrb     = '1;
        o_wdata     = i_src2;
        o_load_data = i_rdata;
        case (w_size)
            SZ_B: begin
                o_wstrb     = STRB_W'(1) << i_off;
                o_wdata     = {STRB_W{i_src2[7:0]}};
                o_load_data = {{(XLEN-8){w_signed & w_byte[7]}}, w_byte};
            end
            SZ_H: begin
                o_wstrb     = STRB_W'(3) << i_off;
                o_wdata     = {(XLEN/16){i_src2[15:0]}};
                o_load_data = {{(XLEN-16){w_signed & w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

`ifdef YSYX_23060251_LSU_MISALIGN_CHK_EN
    assign o_misaligned = ((w_size == SZ_H) && i_off[0]) ||
                          ((w_size == SZ_W) && (i_off != '0));
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/lsu.sv
//==============================================================================
// Module  : lsu
// Brief   : Memory-access stage: one outstanding load/store on a valid/ready
//           bus, registered result to writeback. Optional misaligned-access
//           trap with YSYX_23060251_LSU_MISALIGN_CHK_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = c_XLEN,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                E_valid_i,
    output logic                m_ready_o,
    input  logic                is_load_i,
    input  logic                is_store_i,
    input  logic [2:0]          funct3_i,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [4:0]          rd_i,
    input  logic                wen_i,
    input  logic [XLEN-1:0]     res_i,
    input  logic [XLEN-1:0]     src2_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic                mem_req_wen_o,
    output logic [XLEN-1:0]     mem_req_wdata_o,
    output logic [XLEN/8-1:0]   mem_req_wstrb_o,
    input  logic                mem_rsp_valid_i,
    output logic                mem_rsp_ready_o,
    input  logic [XLEN-1:0]     mem_rsp_rdata_i,
    input  logic                mem_rsp_err_i,
    output logic                m_valid_o,
    input  logic                W_ready_i,
    output logic [XLEN-1:0]     m_pc_o,
    output logic [4:0]          m_rd_o,
    output logic                m_wen_o,
    output logic [XLEN-1:0]     m_wdata_o,
    output logic                m_err_o
);

    localparam int c_STRB = XLEN / 8;
    localparam int c_OFF  = $clog2(c_STRB);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;

    logic [XLEN-1:0]   r_pc;
    logic [4:0]        r_rd;
    logic              r_wen;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_src2;
    logic              r_is_load;
    logic              r_is_store;
    logic [XLEN-1:0]   r_wdata;
    logic              r_err;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_misaligned;
    logic              w_mem_fault;
    logic              w_req;
    logic              w_rsp_fire;
    logic [2:0]        w_al_funct3;
    logic [c_OFF-1:0]  w_al_off;
    logic [c_STRB-1:0] w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_load_data;

    assign m_ready_o   = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && W_ready_i);
    assign w_accept    = E_valid_i && m_ready_o;
    assign w_is_mem    = is_load_i || is_store_i;
    assign w_mem_fault = w_is_mem && w_misaligned;
    assign w_req       = (r_state == ST_REQ);
    assign w_rsp_fire  = (r_state == ST_RESP) && mem_rsp_valid_i;

    // While accepting, the aligner looks at the incoming op so the misalign
    // decision is available in the accept cycle; otherwise at the held op.
    assign w_al_funct3 = m_ready_o ? funct3_i : r_funct3;
    assign w_al_off    = m_ready_o ? res_i[c_OFF-1:0] : r_addr[c_OFF-1:0];

    lsu_align #(
        .XLEN   (XLEN),
        .STRB_W (c_STRB),
        .OFF_W  (c_OFF)
    ) u_align (
        .i_funct3     (w_al_funct3),
        .i_off        (w_al_off),
        .i_src2       (r_src2),
        .i_rdata      (mem_rsp_rdata_i),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_accept) begin
                    w_state_nxt = (w_is_mem && !w_misaligned) ? ST_REQ : ST_HOLD;
                end else if (m_ready_o) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready_i) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rsp_valid_i) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc       <= '0;
            r_rd       <= '0;
            r_wen      <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_src2     <= '0;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_pc       <= pc_i;
            r_rd       <= rd_i;
            r_funct3   <= funct3_i;
            r_addr     <= res_i[ADDR_W-1:0];
            r_src2     <= src2_i;
            r_is_load  <= is_load_i;
            r_is_store <= is_store_i;
            // res doubles as mtval when the access traps on alignment.
            r_wdata    <= res_i;
            r_wen      <= wen_i && !w_mem_fault;
            r_err      <= w_mem_fault;
        end else if (w_rsp_fire) begin
            if (r_is_load) begin
                r_wdata <= w_load_data;
            end
            if (r_is_store || mem_rsp_err_i) begin
                r_wen <= 1'b0;
            end
            r_err <= mem_rsp_err_i;
        end
    end

    assign mem_req_valid_o = w_req;
    assign mem_req_addr_o  = r_addr;
    assign mem_req_wen_o   = w_req && r_is_store;
    assign mem_req_wdata_o = w_req ? w_wdata : '0;
    assign mem_req_wstrb_o = w_req ? w_wstrb : '0;
    assign mem_rsp_ready_o = (r_state == ST_RESP);

    assign m_valid_o = (r_state == ST_HOLD);
    assign m_pc_o    = r_pc;
    assign m_rd_o    = r_rd;
    assign m_wen_o   = r_wen;
    assign m_wdata_o = r_wdata;
    assign m_err_o   = r_err;

endmodule

`default_nettype wire
